// File: rtl/ysyx_23060096_imm_pkg.sv
// Shared format codes, field masks and encode/representability helpers for the immediate encoder.
// The slot layout grows by fmt/imm when YSYX_23060096_IMMENC_CHECK_EN is defined.
package ysyx_23060096_imm_pkg;

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_U = 3'b001;
    localparam logic [2:0] FMT_S = 3'b010;
    localparam logic [2:0] FMT_B = 3'b011;
    localparam logic [2:0] FMT_J = 3'b100;

    localparam logic [24:0] MASK_I  = 25'h1FFE000;
    localparam logic [24:0] MASK_UJ = 25'h1FFFFE0;
    localparam logic [24:0] MASK_SB = 25'h1FC001F;

    typedef struct packed {
        logic [24:0] inst;
        logic        err;
    } enc_t;

    typedef struct packed {
        enc_t        enc;
`ifdef YSYX_23060096_IMMENC_CHECK_EN
        logic [2:0]  fmt;
        logic [31:0] imm;
`endif
    } slot_t;

    function automatic logic [24:0] imm_mask(input logic [2:0] fmt);
        case (fmt)
            FMT_I:        return MASK_I;
            FMT_U, FMT_J: return MASK_UJ;
            FMT_S, FMT_B: return MASK_SB;
            default:      return '0;
        endcase
    endfunction

    function automatic logic [24:0] imm_field(input logic [2:0] fmt, input logic [31:0] imm);
        logic [24:0] f;
        f = '0;
        case (fmt)
            FMT_I: f[24:13] = imm[11:0];
            FMT_U: f[24:5]  = imm[31:12];
            FMT_S: begin
                f[24:18] = imm[11:5];
                f[4:0]   = imm[4:0];
            end
            FMT_B: begin
                f[24]    = imm[12];
                f[23:18] = imm[10:5];
                f[4:1]   = imm[4:1];
                f[0]     = imm[11];
            end
            FMT_J: begin
                f[24]    = imm[20];
                f[23:14] = imm[10:1];
                f[13]    = imm[11];
                f[12:5]  = imm[19:12];
            end
            default: f = '0;
        endcase
        return f;
    endfunction

    // A value fits a signed field when every bit above it equals the field's sign bit.
    function automatic logic imm_err(input logic [2:0] fmt, input logic [31:0] imm);
        case (fmt)
            FMT_I, FMT_S: return !((&imm[31:11]) || !(|imm[31:11]));
            FMT_U:        return |imm[11:0];
            FMT_B:        return imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
            FMT_J:        return imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
            default:      return 1'b1;
        endcase
    endfunction

    function automatic enc_t imm_encode(input logic [2:0] fmt, input logic [31:0] imm,
                                        input logic [24:0] base);
        enc_t e;
        e.inst = (base & ~imm_mask(fmt)) | imm_field(fmt, imm);
        e.err  = imm_err(fmt, imm);
        return e;
    endfunction

endpackage

// File: rtl/ysyx_23060096_imm_dec.sv
// Regenerates the sign-extended immediate from an encoded inst[31:7]; built only with
// YSYX_23060096_IMMENC_CHECK_EN to cross-check the encoder.
module ysyx_23060096_imm_dec
    import ysyx_23060096_imm_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [24:0] inst,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{inst[24]}}, inst[24:13]};
            FMT_U:   imm = {inst[24:5], 12'b0};
            FMT_S:   imm = {{20{inst[24]}}, inst[24:18], inst[4:0]};
            FMT_B:   imm = {{19{inst[24]}}, inst[24], inst[0], inst[23:18], inst[4:1], 1'b0};
            FMT_J:   imm = {{11{inst[24]}}, inst[24], inst[12:5], inst[13], inst[23:14], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_23060096_imm_enc.sv
// Streaming RISC-V immediate encoder: one-cycle latency, main register M plus skid register K.
// Defining YSYX_23060096_IMMENC_CHECK_EN adds a decode-back checker with sticky chk_fail output.
module ysyx_23060096_imm_enc
    import ysyx_23060096_imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [31:0]      in_imm,
    input  logic [24:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [24:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef YSYX_23060096_IMMENC_CHECK_EN
    ,
    output logic             chk_fail
`endif
);

    logic  m_valid_reg, m_valid_next;
    logic  k_valid_reg, k_valid_next;
    slot_t m_slot_reg, m_slot_next;
    slot_t k_slot_reg, k_slot_next;
    slot_t new_slot;
    logic  accept, drain, m_free;

    assign in_ready = !k_valid_reg;
    assign accept   = in_valid && in_ready;
    assign drain    = m_valid_reg && out_ready;
    assign m_free   = !m_valid_reg || out_ready;

    always_comb begin
        new_slot     = '0;
        new_slot.enc = imm_encode(in_fmt, in_imm, in_base);
`ifdef YSYX_23060096_IMMENC_CHECK_EN
        new_slot.fmt = in_fmt;
        new_slot.imm = in_imm;
`endif
    end

    // K is only ever filled behind a stalled M, so it is always older than any new entry.
    always_comb begin
        m_valid_next = m_valid_reg;
        m_slot_next  = m_slot_reg;
        k_valid_next = k_valid_reg;
        k_slot_next  = k_slot_reg;
        if (m_free) begin
            if (k_valid_reg) begin
                m_valid_next = 1'b1;
                m_slot_next  = k_slot_reg;
                k_valid_next = 1'b0;
            end else if (accept) begin
                m_valid_next = 1'b1;
                m_slot_next  = new_slot;
            end else begin
                m_valid_next = 1'b0;
            end
        end else if (accept) begin
            k_valid_next = 1'b1;
            k_slot_next  = new_slot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            k_valid_reg <= 1'b0;
            m_slot_reg  <= '0;
            k_slot_reg  <= '0;
        end else begin
            m_valid_reg <= m_valid_next;
            k_valid_reg <= k_valid_next;
            m_slot_reg  <= m_slot_next;
            k_slot_reg  <= k_slot_next;
        end
    end

    assign out_valid = m_valid_reg;
    assign out_inst  = m_slot_reg.enc.inst;
    assign out_err   = m_slot_reg.enc.err;

    // Index 0 counts delivered results, index 1 the delivered ones flagged as errors.
    logic [1:0] cnt_inc;
    assign cnt_inc = {drain && m_slot_reg.enc.err, drain};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && !(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign enc_cnt = g_cnt[0].cnt_reg;
    assign err_cnt = g_cnt[1].cnt_reg;

`ifdef YSYX_23060096_IMMENC_CHECK_EN
    logic [31:0] dec_imm;
    logic        chk_fail_reg;

    ysyx_23060096_imm_dec u_dec (
        .fmt  (m_slot_reg.fmt),
        .inst (m_slot_reg.enc.inst),
        .imm  (dec_imm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_fail_reg <= 1'b0;
        end else if (m_valid_reg && !m_slot_reg.enc.err && (dec_imm != m_slot_reg.imm)) begin
            chk_fail_reg <= 1'b1;
        end
    end

    assign chk_fail = chk_fail_reg;
`endif

endmodule

// File: tb/tb_ysyx_23060096_imm_enc.sv
// Directed bench for the immediate encoder: a queue scoreboard is filled at accept and drained
// by a negedge monitor on every out_valid && out_ready.
module tb_ysyx_23060096_imm_enc;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [31:0]      in_imm;
    logic [24:0]      in_base;
    logic             out_valid;
    logic             out_ready;
    logic [24:0]      out_inst;
    logic             out_err;
    logic [CNT_W-1:0] enc_cnt;
    logic [CNT_W-1:0] err_cnt;
`ifdef YSYX_23060096_IMMENC_CHECK_EN
    logic             chk_fail;
`endif

    ysyx_23060096_imm_enc #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_imm    (in_imm),
        .in_base   (in_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .enc_cnt   (enc_cnt),
        .err_cnt   (err_cnt)
`ifdef YSYX_23060096_IMMENC_CHECK_EN
        ,
        .chk_fail  (chk_fail)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] inst;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total    = 0;
    int   passed   = 0;
    int   xfers    = 0;
    int   exp_enc  = 0;
    int   exp_errc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                $display("xfer %0d: inst=%h err=%b (want %h/%b)", xfers, out_inst, out_err, e.inst, e.err);
                chk("out_inst", 32'(out_inst), 32'(e.inst));
                chk("out_err", 32'(out_err), 32'(e.err));
                exp_enc++;
                if (e.err) exp_errc++;
            end
            xfers++;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [2:0] f, input logic [31:0] imm, input logic [24:0] base,
                        input logic [24:0] ei, input logic ee);
        int n = 0;
        in_fmt   = f;
        in_imm   = imm;
        in_base  = base;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", 32'(in_ready), 32'd1);
        if (in_ready) sb.push_back('{ei, ee});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int base_x;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = '0; in_imm = '0; in_base = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_inst", 32'(out_inst), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_enc_cnt", 32'(enc_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        send(3'b000, 32'hFFFFFFFF, 25'h0, 25'h1FFE000, 1'b0);
        chk("lat_I", 32'(out_valid), 32'd1);
        send(3'b100, 32'h00100000, 25'h0, 25'h1000000, 1'b1);
        chk("lat_J", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        chk("err_cnt_J", 32'(err_cnt), 32'd1);
        chk("enc_cnt_J", 32'(enc_cnt), 32'd2);

        send(3'b011, 32'h00000800, 25'h0, 25'h0000001, 1'b0);
        send(3'b011, 32'h00000801, 25'h0, 25'h0000001, 1'b1);
        send(3'b001, 32'h12345678, 25'h1FFFFFF, 25'h02468BF, 1'b1);
        send(3'b010, 32'hFFFFF800, 25'h0001234, 25'h1001220, 1'b0);
        send(3'b101, 32'h00000000, 25'h0ABCDEF, 25'h0ABCDEF, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("enc_cnt_mix", 32'(enc_cnt), 32'(exp_enc));
        chk("err_cnt_mix", 32'(err_cnt), 32'(exp_errc));

        // Backpressure: two accepts fill M and K, a third request must wait.
        out_ready = 1'b0;
        send(3'b000, 32'h00000005, 25'h0, 25'h000A000, 1'b0);
        send(3'b001, 32'h00001000, 25'h0, 25'h0000020, 1'b0);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_inst", 32'(out_inst), 32'h000A000);
        in_fmt = 3'b100; in_imm = 32'h00000002; in_base = 25'h0; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_hold_inst2", 32'(out_inst), 32'h000A000);
        out_ready = 1'b1;
        base_x = xfers;
        @(posedge clk); #1;
        chk("bp_ready_again", 32'(in_ready), 32'd1);
        sb.push_back('{25'h0004000, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_no_gap", 32'(xfers - base_x), 32'd3);
        chk("bp_enc_cnt", 32'(enc_cnt), 32'(exp_enc));

        // Reset in the middle of a stall discards everything in flight.
        out_ready = 1'b0;
        send(3'b000, 32'h00000001, 25'h0, 25'h0002000, 1'b0);
        send(3'b000, 32'h00000002, 25'h0, 25'h0004000, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_enc", 32'(enc_cnt), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        sb.delete();
        exp_enc = 0;
        exp_errc = 0;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(out_valid), 32'd0);

        send(3'b000, 32'hFFFFFFFF, 25'h1FFFFFF, 25'h1FFFFFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("final_enc_cnt", 32'(enc_cnt), 32'(exp_enc));
        chk("final_err_cnt", 32'(err_cnt), 32'(exp_errc));
        chk("sb_drained", 32'(sb.size()), 32'd0);
`ifdef YSYX_23060096_IMMENC_CHECK_EN
        chk("chk_fail", 32'(chk_fail), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
